mul_div_unit: RTL and testbench

Parametrised iterative multiply/divide unit that sits beside the EX-stage ALU. It executes MIPS-style MULT, MULTU, DIV and DIVU and writes the results to architectural HI/LO registers. It takes multiple cycles and uses a start/busy/done handshake, so the pipeline stalls on busy. A cancel input supports branch flushes, and a divide-by-zero path completes early.

---
 rtl/mul_div_if.sv | 28 ++
 rtl/mul_div_unit.sv | 184 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_if.sv
// Handshake and data bundle between the EX-stage pipeline and the iterative multiply/divide unit.
interface mul_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, cancel, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, cancel, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Signed operations run on magnitudes; the sign is applied in the FIN state.
module mul_div_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic     clk,
    input  logic     rst,
    mul_div_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nx_s;
    logic                 accept_s;
    logic                 is_div_s;
    logic                 signed_s;
    logic                 b_zero_s;
    logic [WIDTH-1:0]     a_mag_s;
    logic [WIDTH-1:0]     b_mag_s;
    logic [2*WIDTH-1:0]   acc_r;
    logic [2*WIDTH-1:0]   acc_step_s;
    logic [WIDTH-1:0]     opnd_r;
    logic                 is_div_r;
    logic                 neg_res_r;
    logic                 neg_rem_r;
    logic                 dbz_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [WIDTH:0]       mul_sum_s;
    logic [WIDTH:0]       rem_shift_s;
    logic [WIDTH-1:0]     rem_diff_s;
    logic [2*WIDTH-1:0]   prod_fix_s;
    logic [WIDTH-1:0]     quot_fix_s;
    logic [WIDTH-1:0]     rem_fix_s;
    logic                 wr_ok_s;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 div_by_zero_r;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? ({WIDTH{1'b0}} - v) : v;
    endfunction

    // Operand decode for a start request
    always_comb begin
        is_div_s = bus.op[1];
        signed_s = ~bus.op[0];
        b_zero_s = (bus.b == {WIDTH{1'b0}});
        a_mag_s  = mag(bus.a, signed_s);
        b_mag_s  = mag(bus.b, signed_s);
    end

    // Next-state logic; cancel aborts any non-idle state without a done pulse
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start && !bus.cancel) begin
                    accept_s   = 1'b1;
                    state_nx_s = (is_div_s && b_zero_s) ? ST_FIN : ST_CALC;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (bus.cancel) begin
                    state_nx_s = ST_IDLE;
                end else if (cnt_r == CNT_W'(WIDTH - 1)) begin
                    state_nx_s = ST_FIN;
                end else begin
                    state_nx_s = ST_CALC;
                end
            end
            ST_FIN:  state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
        rem_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        rem_diff_s  = rem_shift_s[WIDTH-1:0] - opnd_r;
        if (is_div_r) begin
            if (rem_shift_s >= {1'b0, opnd_r}) begin
                acc_step_s = {rem_diff_s, acc_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_step_s = {rem_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (acc_r[0]) begin
                acc_step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
            end else begin
                acc_step_s = {1'b0, acc_r[2*WIDTH-1:1]};
            end
        end
    end

    // Sign fix-up of the finished magnitude result; MTHI/MTLO gating
    always_comb begin
        prod_fix_s = neg_res_r ? ({2*WIDTH{1'b0}} - acc_r) : acc_r;
        quot_fix_s = neg_res_r ? ({WIDTH{1'b0}} - acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
        rem_fix_s  = neg_rem_r ? ({WIDTH{1'b0}} - acc_r[2*WIDTH-1:WIDTH])
                               : acc_r[2*WIDTH-1:WIDTH];
        wr_ok_s    = !busy_r && !done_r;
    end

    // State, datapath and architectural register updates
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            acc_r         <= {2*WIDTH{1'b0}};
            opnd_r        <= {WIDTH{1'b0}};
            is_div_r      <= 1'b0;
            neg_res_r     <= 1'b0;
            neg_rem_r     <= 1'b0;
            dbz_r         <= 1'b0;
            cnt_r         <= {CNT_W{1'b0}};
            hi_r          <= {WIDTH{1'b0}};
            lo_r          <= {WIDTH{1'b0}};
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            div_by_zero_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != ST_IDLE);
            done_r  <= 1'b0;
            if (accept_s) begin
                cnt_r    <= {CNT_W{1'b0}};
                is_div_r <= is_div_s;
                if (is_div_s && b_zero_s) begin
                    // Zero divisor: result preloaded so FIN can pass it straight through
                    acc_r     <= {bus.a, {WIDTH{1'b1}}};
                    opnd_r    <= {WIDTH{1'b0}};
                    neg_res_r <= 1'b0;
                    neg_rem_r <= 1'b0;
                    dbz_r     <= 1'b1;
                end else begin
                    acc_r     <= {{WIDTH{1'b0}}, (is_div_s ? a_mag_s : b_mag_s)};
                    opnd_r    <= is_div_s ? b_mag_s : a_mag_s;
                    neg_res_r <= signed_s & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    neg_rem_r <= signed_s & is_div_s & bus.a[WIDTH-1];
                    dbz_r     <= 1'b0;
                end
            end else if (state_r == ST_CALC) begin
                acc_r <= acc_step_s;
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if ((state_r == ST_FIN) && !bus.cancel) begin
                done_r <= 1'b1;
                if (is_div_r) begin
                    hi_r          <= rem_fix_s;
                    lo_r          <= quot_fix_s;
                    div_by_zero_r <= dbz_r;
                end else begin
                    hi_r <= prod_fix_s[2*WIDTH-1:WIDTH];
                    lo_r <= prod_fix_s[WIDTH-1:0];
                end
            end else begin
                if (wr_ok_s && bus.hi_we) begin
                    hi_r <= bus.wdata;
                end
                if (wr_ok_s && bus.lo_we) begin
                    lo_r <= bus.wdata;
                end
            end
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = div_by_zero_r;
    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases, randomized ops against an arithmetic model,
// cancel/reset aborts and back-to-back issue.
module tb_mul_div_unit;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    mul_div_if #(.WIDTH(32)) bus();

    mul_div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start  = 1'b0;
        bus.op     = 2'd0;
        bus.a      = 32'h0;
        bus.b      = 32'h0;
        bus.cancel = 1'b0;
        bus.hi_we  = 1'b0;
        bus.lo_we  = 1'b0;
        bus.wdata  = 32'h0;
    endtask

    // Reference: full-precision arithmetic; 64-bit signed divide handles MIN_INT/-1 naturally
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: return 64'(sa * sb);
            2'd1: return {32'h0, a} * {32'h0, b};
            2'd2: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Drive an accepted start at the next edge; scramble operands afterwards
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        tick();
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.a     = 32'($urandom);
        bus.b     = 32'($urandom);
    endtask

    // Wait for done (bounded); optionally drive ignored start/MTHI/MTLO traffic while busy
    task automatic wait_done(input bit noise, output int lat, output int busy_cyc);
        lat      = 0;
        busy_cyc = 0;
        while (bus.done !== 1'b1 && lat < 200) begin
            if (bus.busy === 1'b1) busy_cyc++;
            if (noise) begin
                bus.start = 1'($urandom);
                bus.hi_we = 1'($urandom);
                bus.lo_we = 1'($urandom);
                bus.wdata = 32'($urandom);
            end
            tick();
            lat++;
        end
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'hFFFF_FFFF;
        tick();
        tick();
        n_checks++;
        if ({bus.hi, bus.lo, bus.busy, bus.done, bus.div_by_zero} !== 67'h0) begin
            n_fail++;
            $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b dbz=%b, expected all zero",
                     bus.hi, bus.lo, bus.busy, bus.done, bus.div_by_zero);
        end
        idle_inputs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        logic [1:0]  ops  [7] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0, 2'd3};
        logic [31:0] as   [7] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000,
                                  32'd100, 32'd3, 32'd100};
        logic [31:0] bs   [7] = '{32'd5, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd4, 32'd7};
        logic [63:0] exps [7] = '{64'hFFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFE_0000_0001,
                                  64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0000_8000_0000,
                                  64'h0000_0064_FFFF_FFFF, 64'h0000_0000_0000_000C,
                                  64'h0000_0002_0000_000E};
        int          lats [7] = '{33, 33, 33, 33, 1, 33, 33};
        logic        dbzs [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int lat;
        int bc;
        for (int i = 0; i < 7; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(1'b0, lat, bc);
            n_checks++;
            if ({bus.hi, bus.lo} !== exps[i]) begin
                n_fail++;
                $display("FAIL directed_result[%0d]: got %h_%h, expected %h", i, bus.hi, bus.lo, exps[i]);
            end
            n_checks++;
            if (lat !== lats[i] || bc !== lats[i]) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: got lat=%0d busy_cycles=%0d, expected %0d",
                         i, lat, bc, lats[i]);
            end
            n_checks++;
            if (bus.div_by_zero !== dbzs[i] || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_flags[%0d]: got dbz=%b busy=%b, expected dbz=%b busy=0",
                         i, bus.div_by_zero, bus.busy, dbzs[i]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_res;
        logic        exp_dbz;
        int          exp_lat;
        int lat;
        int bc;
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        exp_dbz = 1'b0;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            a  = pick_operand();
            b  = pick_operand();
            exp_res = ref_result(op, a, b);
            exp_lat = (op[1] && b == 32'h0) ? 1 : 33;
            if (op[1]) exp_dbz = (b == 32'h0);
            issue(op, a, b);
            wait_done(1'(i % 2), lat, bc);
            n_checks++;
            if ({bus.hi, bus.lo} !== exp_res || lat !== exp_lat) begin
                n_fail++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h_%h lat=%0d, expected %h lat=%0d",
                         i, op, a, b, bus.hi, bus.lo, lat, exp_res, exp_lat);
            end
            n_checks++;
            if (bus.div_by_zero !== exp_dbz) begin
                n_fail++;
                $display("FAIL random_dbz[%0d]: got %b, expected %b", i, bus.div_by_zero, exp_dbz);
            end
        end
        tick();
    endtask

    task automatic test_cancel();
        int lat;
        int bc;
        int dones;
        issue(2'd3, 32'd5, 32'd0);
        wait_done(1'b0, lat, bc);
        tick();
        bus.hi_we = 1'b1;
        bus.wdata = 32'h1234_5678;
        tick();
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h9ABC_DEF0;
        tick();
        bus.lo_we = 1'b0;
        n_checks++;
        if ({bus.hi, bus.lo} !== 64'h1234_5678_9ABC_DEF0) begin
            n_fail++;
            $display("FAIL mthi_mtlo_idle: got %h_%h, expected 12345678_9abcdef0", bus.hi, bus.lo);
        end
        issue(2'd2, 32'd9, 32'd3);
        repeat (9) tick();
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL cancel_busy: got busy=%b done=%b, expected 0 0", bus.busy, bus.done);
        end
        bus.start  = 1'b1;
        bus.cancel = 1'b1;
        bus.op     = 2'd1;
        tick();
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cancel_with_start: got busy=%b, expected 0", bus.busy);
        end
        dones = 0;
        repeat (40) begin
            if (bus.done === 1'b1) dones++;
            tick();
        end
        n_checks++;
        if (dones !== 0 || {bus.hi, bus.lo} !== 64'h1234_5678_9ABC_DEF0 || bus.div_by_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL cancel_retain: got dones=%0d hi_lo=%h_%h dbz=%b, expected 0 12345678_9abcdef0 1",
                     dones, bus.hi, bus.lo, bus.div_by_zero);
        end
        issue(2'd0, 32'd7, 32'd9);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({bus.hi, bus.lo, bus.busy, bus.done, bus.div_by_zero} !== 67'h0) begin
            n_fail++;
            $display("FAIL reset_midop: got hi=%h lo=%h busy=%b done=%b dbz=%b, expected all zero",
                     bus.hi, bus.lo, bus.busy, bus.done, bus.div_by_zero);
        end
        dones = 0;
        repeat (40) begin
            if (bus.done === 1'b1) dones++;
            tick();
        end
        issue(2'd1, 32'd6, 32'd7);
        wait_done(1'b0, lat, bc);
        n_checks++;
        if (dones !== 0 || {bus.hi, bus.lo} !== 64'd42 || lat !== 33) begin
            n_fail++;
            $display("FAIL after_reset_op: got dones=%0d hi_lo=%h_%h lat=%0d, expected 0 42 33",
                     dones, bus.hi, bus.lo, lat);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        int bc;
        issue(2'd1, 32'h0001_0000, 32'h0001_0000);
        wait_done(1'b0, lat, bc);
        n_checks++;
        if ({bus.hi, bus.lo} !== 64'h0000_0001_0000_0000) begin
            n_fail++;
            $display("FAIL b2b_first: got %h_%h, expected 00000001_00000000", bus.hi, bus.lo);
        end
        bus.start = 1'b1;
        bus.op    = 2'd3;
        bus.a     = 32'd1000;
        bus.b     = 32'd3;
        bus.lo_we = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        tick();
        bus.start = 1'b0;
        bus.lo_we = 1'b0;
        bus.a     = 32'($urandom);
        n_checks++;
        if (bus.busy !== 1'b1 || {bus.hi, bus.lo} !== 64'h0000_0001_0000_0000) begin
            n_fail++;
            $display("FAIL b2b_accept: got busy=%b hi_lo=%h_%h, expected 1 00000001_00000000",
                     bus.busy, bus.hi, bus.lo);
        end
        wait_done(1'b1, lat, bc);
        n_checks++;
        if ({bus.hi, bus.lo} !== {32'd1, 32'd333} || lat !== 33) begin
            n_fail++;
            $display("FAIL b2b_second: got %h_%h lat=%0d, expected 00000001_0000014d lat=33",
                     bus.hi, bus.lo, lat);
        end
        tick();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_start_ignored: got busy=%b done=%b, expected 0 0", bus.busy, bus.done);
        end
        bus.lo_we = 1'b1;
        bus.wdata = 32'hCAFE_0042;
        tick();
        bus.lo_we = 1'b0;
        n_checks++;
        if ({bus.hi, bus.lo} !== 64'h0000_0001_CAFE_0042) begin
            n_fail++;
            $display("FAIL mtlo_idle: got %h_%h, expected 00000001_cafe0042", bus.hi, bus.lo);
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_cancel();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
